// File: rtl/gray_seq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gray_seq_arbiter
// Description : Two-requester round-robin arbiter that plays a Gray-code
//               sequence of the winner's requested length, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_seq_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] gray_out,
    output logic             gray_vld,
    output logic [1:0]       done,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Count is one bit wider than the code so a length of 2^WIDTH fits.
    localparam logic [WIDTH:0] c_full = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] c_one  = {{WIDTH{1'b0}}, 1'b1};

    state_t           r_state, w_state;
    logic [WIDTH:0]   r_cnt, w_cnt;
    logic [WIDTH:0]   r_n, w_n;
    logic             r_win, w_win;
    logic             r_last, w_last;
    logic [1:0]       r_gnt, w_gnt;
    logic [WIDTH-1:0] r_gray, w_gray;
    logic             r_vld, w_vld;
    logic [1:0]       r_done, w_done;
    logic             r_busy, w_busy;

    logic             w_pick;
    logic [WIDTH-1:0] w_len;
    logic [WIDTH:0]   w_cnt_inc;

    always_comb begin
        case (req)
            2'b01:   w_pick = 1'b0;
            2'b10:   w_pick = 1'b1;
            default: w_pick = ~r_last;
        endcase
    end

    assign w_len     = w_pick ? len1 : len0;
    assign w_cnt_inc = r_cnt + c_one;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_n     = r_n;
        w_win   = r_win;
        w_last  = r_last;
        w_gnt   = r_gnt;
        w_gray  = r_gray;
        w_vld   = r_vld;
        w_done  = 2'b00;
        w_busy  = r_busy;
        case (r_state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    w_state = S_RUN;
                    w_win   = w_pick;
                    w_last  = w_pick;
                    w_n     = (w_len == '0) ? c_full : {1'b0, w_len};
                    w_cnt   = '0;
                    w_gnt   = w_pick ? 2'b10 : 2'b01;
                    w_gray  = '0;
                    w_vld   = 1'b1;
                    w_busy  = 1'b1;
                end
            end
            S_RUN: begin
                if (!req[r_win]) begin
                    // Winner withdrew: abandon quietly, pointer keeps it as last served.
                    w_state = S_IDLE;
                    w_gnt   = 2'b00;
                    w_vld   = 1'b0;
                    w_busy  = 1'b0;
                end else if (r_cnt == r_n - c_one) begin
                    w_state = S_DONE;
                    w_gnt   = 2'b00;
                    w_vld   = 1'b0;
                    w_done  = r_win ? 2'b10 : 2'b01;
                end else begin
                    w_cnt  = w_cnt_inc;
                    w_gray = w_cnt_inc[WIDTH-1:0] ^ (w_cnt_inc[WIDTH-1:0] >> 1);
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
                w_gnt   = 2'b00;
                w_vld   = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_n     <= '0;
            r_win   <= 1'b0;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
            r_gray  <= '0;
            r_vld   <= 1'b0;
            r_done  <= 2'b00;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_n     <= w_n;
            r_win   <= w_win;
            r_last  <= w_last;
            r_gnt   <= w_gnt;
            r_gray  <= w_gray;
            r_vld   <= w_vld;
            r_done  <= w_done;
            r_busy  <= w_busy;
        end
    end

    assign gnt      = r_gnt;
    assign gray_out = r_gray;
    assign gray_vld = r_vld;
    assign done     = r_done;
    assign busy     = r_busy;

endmodule
`default_nettype wire
